// File: rtl/prime_range_scanner_if.sv
// prime_range_scanner_if: request, candidate handshake, verdict and result
// signals between a scan requester / prime checker and the range scanner.
interface prime_range_scanner_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] cand;
    logic             cand_valid;
    logic             cand_ready;
    logic             res_valid;
    logic             res_prime;
    logic [WIDTH-1:0] prime_count;
    logic [WIDTH-1:0] last_prime;

    modport master (
        output start, lo, hi, cand_ready, res_valid, res_prime,
        input  busy, done, cand, cand_valid, prime_count, last_prime
    );

    modport slave (
        input  start, lo, hi, cand_ready, res_valid, res_prime,
        output busy, done, cand, cand_valid, prime_count, last_prime
    );
endinterface

// File: rtl/prime_range_scanner.sv
// prime_range_scanner: walks every candidate in [lo, hi], hands each to an
// external prime checker over a valid/ready handshake, and tallies the primes.
// Optional build macro PRIME_ODD_SKIP_EN: even candidates other than 2 are not
// issued and count as non-prime, saving the checker round trip.
module prime_range_scanner #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    prime_range_scanner_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] cand_q, cand_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] last_q, last_n;
    logic             cand_valid;

`ifdef PRIME_ODD_SKIP_EN
    logic skip;
    assign skip = (cand_q[0] == 1'b0) && (cand_q != WIDTH'(2));
`endif

    // State and datapath registers; reset abandons any scan in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cand_q  <= '0;
            hi_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            state   <= state_n;
            cand_q  <= cand_n;
            hi_q    <= hi_n;
            count_q <= count_n;
            last_q  <= last_n;
        end
    end

    // Next-state, datapath update and handshake output decode.
    always_comb begin
        state_n    = state;
        cand_n     = cand_q;
        hi_n       = hi_q;
        count_n    = count_q;
        last_n     = last_q;
        cand_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    count_n = '0;
                    last_n  = '0;
                    if (bus.lo <= bus.hi) begin
                        hi_n    = bus.hi;
                        cand_n  = bus.lo;
                        state_n = ISSUE;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ISSUE: begin
`ifdef PRIME_ODD_SKIP_EN
                // A skipped even candidate takes the same advance/finish path
                // a non-prime verdict would, just without leaving ISSUE.
                if (skip) begin
                    if (cand_q == hi_q) begin
                        state_n = DONE;
                    end else begin
                        cand_n = cand_q + ONE;
                    end
                end else begin
                    cand_valid = 1'b1;
                    if (bus.cand_ready) begin
                        state_n = WAIT;
                    end
                end
`else
                cand_valid = 1'b1;
                if (bus.cand_ready) begin
                    state_n = WAIT;
                end
`endif
            end
            WAIT: begin
                if (bus.res_valid) begin
                    if (bus.res_prime) begin
                        count_n = count_q + ONE;
                        last_n  = cand_q;
                    end
                    // Compare before incrementing so hi = all-ones never wraps.
                    if (cand_q == hi_q) begin
                        state_n = DONE;
                    end else begin
                        cand_n  = cand_q + ONE;
                        state_n = ISSUE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.cand        = cand_q;
    assign bus.cand_valid  = cand_valid;
    assign bus.prime_count = count_q;
    assign bus.last_prime  = last_q;
endmodule

// File: doc/prime_range_scanner.md
PRIME_RANGE_SCANNER -- requirements
Module: prime_range_scanner

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of candidates, bounds and counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request, sampled in IDLE only.
REQ-005 lo  input  WIDTH  lower bound, inclusive, sampled with start.
REQ-006 hi  input  WIDTH  upper bound, inclusive, sampled with start.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 done  output  1  one-cycle pulse when the scan completes.
REQ-009 cand  output  WIDTH  candidate presented to the downstream prime checker.
REQ-010 cand_valid  output  1  cand is valid.
REQ-011 cand_ready  input  1  checker accepts cand.
REQ-012 res_valid  input  1  checker verdict valid.
REQ-013 res_prime  input  1  verdict: 1 = prime.
REQ-014 prime_count  output  WIDTH  number of primes found in the current or last scan.
REQ-015 last_prime  output  WIDTH  largest prime found; 0 if none.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE with start=1 and lo<=hi, the block SHALL latch lo/hi, clear prime_count and last_prime, load cand=lo, and enter ISSUE next cycle.
REQ-018 In IDLE with start=1 and lo>hi, the block SHALL clear prime_count and last_prime, and enter DONE next cycle.
REQ-019 In ISSUE, cand_valid SHALL be 1; cand SHALL stay stable until cand_valid&&cand_ready, then the FSM enters WAIT with cand_valid=0 the next cycle.
REQ-020 In WAIT with res_valid=1 and res_prime=1, the block SHALL increment prime_count and set last_prime=cand.
REQ-021 In WAIT with res_valid=1, the FSM SHALL enter DONE if cand==latched hi; otherwise it SHALL set cand=cand+1 and enter ISSUE.
REQ-022 cand SHALL never increment past hi, so hi=2^WIDTH-1 terminates without wrap-around.
REQ-023 res_valid outside WAIT SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 prime_count and last_prime SHALL hold their values in IDLE until the next accepted start.
REQ-026 Minimum per-candidate cost SHALL be 2 cycles: one ISSUE cycle and one WAIT cycle.

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately, from any state including mid-scan.
REQ-028 In reset, cand, prime_count and last_prime SHALL be 0, and cand_valid, busy and done SHALL be 0.
REQ-029 A scan interrupted by reset SHALL NOT resume; a verdict arriving after reset SHALL be ignored.

Configuration
REQ-030 Macro PRIME_ODD_SKIP_EN SHALL control even-candidate skipping.
REQ-031 With PRIME_ODD_SKIP_EN defined: in ISSUE, an even cand other than 2 SHALL not be issued (cand_valid stays 0); it is treated as a non-prime verdict that cycle, and the REQ-021 advance/finish rule applies.
REQ-032 Without the macro, every candidate in [lo,hi] SHALL be issued.
REQ-033 prime_count and last_prime SHALL be identical with and without the macro.

Verification
REQ-034 lo=2, hi=31, cand_ready=1, reference checker responding in 1 cycle -> prime_count=11, last_prime=31, one done pulse, busy low afterwards.
REQ-035 lo=20, hi=5, start -> done on the cycle after the IDLE->DONE transition, prime_count=0, last_prime=0, cand_valid never asserted.
REQ-036 lo=2^32-3, hi=2^32-1 -> exactly 3 handshakes (macro off), cand ends at 2^32-1 with no wrap, done pulses once.
REQ-037 cand_ready held low 10 cycles in ISSUE -> cand_valid=1 and cand unchanged for all 10 cycles, and no count change.
REQ-038 rst_n pulsed low in WAIT during scan 2..31 -> outputs 0 immediately; a later res_valid is ignored; a new scan lo=2, hi=7 gives prime_count=4.
REQ-039 lo=2, hi=10 -> handshakes for 2,3,5,7,9 (5) with PRIME_ODD_SKIP_EN and 9 without; prime_count=4 and last_prime=7 in both builds.
